// File: rtl/fust_s_sched_if.sv
// Dispatch / read-operand / writeback handshake bundle for the scalar FU scoreboard.
// Latency: none, this is only wiring.
// Backpressure: disp_ready and wb_grant are the only stall signals toward the producers.
interface fust_s_sched_if;
  logic       disp_valid;
  logic       disp_ready;
  logic [1:0] disp_fu;
  logic [4:0] disp_rd;
  logic [4:0] disp_rs1;
  logic [4:0] disp_rs2;
  logic [2:0] rd_grant;
  logic [2:0] wb_req;
  logic [2:0] wb_grant;
  logic       wb_we;
  logic [4:0] wb_rd;
  logic [2:0] fu_busy;
  logic       stall_struct;
  logic       stall_waw;

  // Dispatch stage and function units drive requests into the scheduler.
  modport master (
    output disp_valid, disp_fu, disp_rd, disp_rs1, disp_rs2, wb_req,
    input  disp_ready, rd_grant, wb_grant, wb_we, wb_rd, fu_busy, stall_struct, stall_waw
  );

  // Scheduler side.
  modport slave (
    input  disp_valid, disp_fu, disp_rd, disp_rs1, disp_rs2, wb_req,
    output disp_ready, rd_grant, wb_grant, wb_we, wb_rd, fu_busy, stall_struct, stall_waw
  );
endinterface

// File: rtl/fust_s_sched.sv
// Scoreboard for the scalar FUs (ALU=0, LD_ST=1, BRANCH=2): dispatch, RAW read release, WAR-safe writeback.
// Latency: disp_ready/wb_grant combinational on registered state; rd_grant earliest one cycle after accept.
// Backpressure: dispatch held off on busy FU or pending rd; wb_req held until granted. Macro FUST_WB_RR_EN selects round-robin writeback.
module fust_s_sched (
  input  logic          CLK,
  input  logic          RST,
  fust_s_sched_if.slave sif
);
  localparam int NREGS  = 32;
  localparam int NFU    = 3;
  localparam int REG_W  = 5;
  localparam int FU_S_W = 2;
  localparam logic [FU_S_W-1:0] TAG_NONE = 2'b11;

  // FU status table and register result-status table
  logic [NFU-1:0]    busy_q, busy_d;
  logic [NFU-1:0]    read_q, read_d;
  logic [REG_W-1:0]  r_q  [NFU];
  logic [REG_W-1:0]  r_d  [NFU];
  logic [REG_W-1:0]  r1_q [NFU];
  logic [REG_W-1:0]  r1_d [NFU];
  logic [REG_W-1:0]  r2_q [NFU];
  logic [REG_W-1:0]  r2_d [NFU];
  logic [FU_S_W-1:0] t1_q [NFU];
  logic [FU_S_W-1:0] t1_d [NFU];
  logic [FU_S_W-1:0] t2_q [NFU];
  logic [FU_S_W-1:0] t2_d [NFU];
  logic [FU_S_W-1:0] rstat_q [NREGS];
  logic [FU_S_W-1:0] rstat_d [NREGS];

`ifdef FUST_WB_RR_EN
  logic [FU_S_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

  logic              fu_legal, row_busy, rd_pending, disp_ok;
  logic [NFU-1:0]    rd_gnt, war, wb_elig, wb_gnt;
  logic              gnt_any;
  logic [FU_S_W-1:0] gnt_id;
  logic [REG_W-1:0]  gnt_rd;
  logic [FU_S_W-1:0] new_t1, new_t2;

  // Dispatch acceptance: structural (target row busy) and WAW (rd already pending)
  always_comb begin
    fu_legal = (sif.disp_fu != 2'd3);
    row_busy = 1'b0;
    for (int f = 0; f < NFU; f++) begin
      if (sif.disp_fu == f[FU_S_W-1:0]) row_busy = busy_q[f];
    end
    rd_pending = (sif.disp_rd != '0) && (rstat_q[sif.disp_rd] != TAG_NONE);
    disp_ok    = !RST && sif.disp_valid && fu_legal && !row_busy && !rd_pending;
  end

  // Read-operand release and writeback eligibility (WAR: an un-read consumer still needs the old value)
  always_comb begin
    rd_gnt  = '0;
    war     = '0;
    wb_elig = '0;
    for (int f = 0; f < NFU; f++) begin
      rd_gnt[f] = !RST && busy_q[f] && !read_q[f] && (t1_q[f] == TAG_NONE) && (t2_q[f] == TAG_NONE);
      for (int g = 0; g < NFU; g++) begin
        if (g != f && busy_q[g] && !read_q[g] && (r_q[f] != '0) &&
            (((r1_q[g] == r_q[f]) && (t1_q[g] == TAG_NONE)) ||
             ((r2_q[g] == r_q[f]) && (t2_q[g] == TAG_NONE))))
          war[f] = 1'b1;
      end
      wb_elig[f] = !RST && sif.wb_req[f] && busy_q[f] && read_q[f] && !war[f];
    end
  end

  // Single write port arbitration among eligible FUs
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
`ifdef FUST_WB_RR_EN
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < NFU; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NFU;
      if (!gnt_any && wb_elig[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx[FU_S_W-1:0];
      end
    end
    if (gnt_any) rr_ptr_d = (gnt_id == 2'd2) ? 2'd0 : gnt_id + 2'd1;
`else
    // Descending scan so the lowest eligible id is the last one written
    for (int f = NFU - 1; f >= 0; f--) begin
      if (wb_elig[f]) begin
        gnt_any = 1'b1;
        gnt_id  = f[FU_S_W-1:0];
      end
    end
`endif
    wb_gnt = '0;
    gnt_rd = '0;
    for (int f = 0; f < NFU; f++) begin
      if (gnt_any && gnt_id == f[FU_S_W-1:0]) begin
        wb_gnt[f] = 1'b1;
        gnt_rd    = r_q[f];
      end
    end
  end

  // Next-state for the FU rows and result-status table
  always_comb begin
    busy_d  = busy_q;
    read_d  = read_q | rd_gnt;
    r_d     = r_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    rstat_d = rstat_q;

    // Tags sampled at dispatch, with a same-cycle writeback of that producer already resolved
    new_t1 = (sif.disp_rs1 == '0) ? TAG_NONE : rstat_q[sif.disp_rs1];
    new_t2 = (sif.disp_rs2 == '0) ? TAG_NONE : rstat_q[sif.disp_rs2];
    if (gnt_any && new_t1 == gnt_id) new_t1 = TAG_NONE;
    if (gnt_any && new_t2 == gnt_id) new_t2 = TAG_NONE;

    if (gnt_any) begin
      for (int f = 0; f < NFU; f++) begin
        if (t1_q[f] == gnt_id) t1_d[f] = TAG_NONE;
        if (t2_q[f] == gnt_id) t2_d[f] = TAG_NONE;
        if (gnt_id == f[FU_S_W-1:0]) begin
          busy_d[f] = 1'b0;
          read_d[f] = 1'b0;
          r_d[f]    = '0;
          r1_d[f]   = '0;
          r2_d[f]   = '0;
          t1_d[f]   = TAG_NONE;
          t2_d[f]   = TAG_NONE;
        end
      end
      if (gnt_rd != '0 && rstat_q[gnt_rd] == gnt_id) rstat_d[gnt_rd] = TAG_NONE;
    end

    // WAW check guarantees rd is not the register being released above
    if (disp_ok) begin
      for (int f = 0; f < NFU; f++) begin
        if (sif.disp_fu == f[FU_S_W-1:0]) begin
          busy_d[f] = 1'b1;
          read_d[f] = 1'b0;
          r_d[f]    = sif.disp_rd;
          r1_d[f]   = sif.disp_rs1;
          r2_d[f]   = sif.disp_rs2;
          t1_d[f]   = new_t1;
          t2_d[f]   = new_t2;
        end
      end
      if (sif.disp_rd != '0) rstat_d[sif.disp_rd] = sif.disp_fu;
    end
  end

  // Output drive
  always_comb begin
    sif.disp_ready   = disp_ok;
    sif.stall_struct = !RST && sif.disp_valid && fu_legal && row_busy;
    sif.stall_waw    = !RST && sif.disp_valid && rd_pending;
    sif.rd_grant     = rd_gnt;
    sif.wb_grant     = wb_gnt;
    sif.wb_rd        = gnt_rd;
    sif.wb_we        = gnt_any && (gnt_rd != '0);
    sif.fu_busy      = busy_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q <= '0;
      read_q <= '0;
      for (int f = 0; f < NFU; f++) begin
        r_q[f]  <= '0;
        r1_q[f] <= '0;
        r2_q[f] <= '0;
        t1_q[f] <= TAG_NONE;
        t2_q[f] <= TAG_NONE;
      end
      for (int i = 0; i < NREGS; i++) rstat_q[i] <= TAG_NONE;
    end else begin
      busy_q  <= busy_d;
      read_q  <= read_d;
      r_q     <= r_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      rstat_q <= rstat_d;
    end
  end

`ifdef FUST_WB_RR_EN
  // Round-robin pointer
  always_ff @(posedge CLK) begin
    if (RST) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif
endmodule

// File: doc/fust_s_sched.md
Name: fust_s_sched

Overview:
Scoreboard controller for the three scalar function units: ALU=0, LD_ST=1, BRANCH=2.
- Owns the scalar FU status table (busy, r, r1, r2, t1, t2 per FU) and a 32-entry register result-status table.
- Decides dispatch acceptance (structural/WAW), read-operand release (RAW) and writeback grant (WAR plus single write port).
- Sits between dispatch and the scalar FUs/register file.

Parameters:
- NREGS, 32, architectural scalar registers (index width REG_W=5).
- NFU, 3, scalar FUs; FU id width FU_S_W=2.
- TAG_NONE, 2'b11, t1/t2/result-status code meaning "no pending producer".

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  dispatch accepted this cycle (combinational).
- disp_fu  in  2  target FU id (0..2; 3 illegal).
- disp_rd  in  5  destination register (x0 = no write).
- disp_rs1  in  5  source 1 (x0 = unused/always ready).
- disp_rs2  in  5  source 2.
- rd_grant  out  3  one-hot-per-FU pulse: read operands now.
- wb_req  in  3  per-FU writeback request, level, held until granted.
- wb_grant  out  3  one-hot writeback grant (combinational).
- wb_we  out  1  register-file write enable (= |wb_grant and granted rd != 0).
- wb_rd  out  5  register written.
- fu_busy  out  3  per-FU busy bits.
- stall_struct  out  1  disp_valid and target FU busy.
- stall_waw  out  1  disp_valid and rd pending.

Behaviour:
- Reset (RST sampled high at edge): all rows busy=0, read=0, tags=TAG_NONE; result status all TAG_NONE; RR pointer=0. All outputs 0. Reset mid-operation drops in-flight rows with no grants; outputs 0 in the cycle after the reset edge.
- Row state per FU: IDLE -> WAIT_OPS (busy, read=0) -> EXEC (busy, read=1) -> IDLE on wb_grant.
- Dispatch: disp_ready = disp_valid & disp_fu!=3 & !busy[disp_fu] & (disp_rd==0 | rstat[disp_rd]==TAG_NONE). Checks use registered state only. A same-cycle writeback of the target FU or of rd does not unblock; the retry succeeds next cycle.
- On accept (edge N): row gets r/r1/r2; t1=rstat[rs1] (TAG_NONE if rs1==0), same for t2.
  - If a writeback is granted in the same cycle by the FU named in t1/t2, that tag is stored as TAG_NONE.
  - rstat[rd]=disp_fu if rd!=0.
- Read operands: rd_grant[f] = busy & !read & t1==TAG_NONE & t2==TAG_NONE, evaluated on registered state; earliest cycle N+1. Multiple FUs may be granted together; the register file has per-FU read ports. The read bit is set at the edge, so the grant is a single-cycle pulse.
- Writeback eligibility for f: wb_req[f] & busy[f] & read[f] & no WAR. WAR exists if any other row g has busy & !read & ((r1_g==r_f & t1_g==TAG_NONE) | (r2_g==r_f & t2_g==TAG_NONE)) with r_f!=0.
- Among eligible FUs, exactly one is granted: lowest id wins (see optional feature). wb_rd = r of the granted row.
- On grant edge:
  - Clear the granted row.
  - Clear rstat[r] if it still equals f.
  - Every row with t1==f or t2==f sets that tag to TAG_NONE; the dependent's rd_grant appears the next cycle.
- wb_req without busy&read is ignored (no grant). disp_fu==3 is never accepted.
- A dispatch and a writeback of the same FU in one cycle: dispatch is refused (busy seen).

Optional Feature:
FUST_WB_RR_EN:
- Defined: writeback arbitration is round-robin. The search starts at the pointer; the pointer moves to (granted id + 1) mod 3 after each grant.
- Undefined: fixed priority ALU > LD_ST > BRANCH; no pointer register.

Test Plan:
- Reset then dispatch ALU rd=5 rs1=1 rs2=2: disp_ready=1; next cycle rd_grant=3'b001, fu_busy=3'b001; wb_req[0] at +2 -> wb_grant=001, wb_rd=5, wb_we=1; fu_busy=0 one cycle later.
- RAW: ALU writes x5, then LD_ST reads rs1=5. LD_ST rd_grant stays 0 until the cycle after the ALU wb_grant, then pulses once.
- WAW/structural: second ALU op gets disp_ready=0, stall_struct=1. A BRANCH op with rd=5 while x5 is pending gets stall_waw=1; it is accepted in the cycle after the x5 writeback.
- WAR: LD_ST dispatched with rs1=7, blocked on rs2 (t2=ALU); BRANCH writing x7 requests wb. wb_grant[2]=0 until LD_ST rd_grant pulses, then granted the next cycle.
- Arbitration: wb_req=3'b111 with all eligible, for three cycles. Grant order without the macro is 001, 010, 100 (each granted row clears, so the next-lowest eligible FU wins). With FUST_WB_RR_EN, starting from pointer=1, order is 010, 100, 001.
- RST asserted while two rows are busy: next cycle fu_busy=0, rstat cleared, and no rd_grant/wb_grant despite wb_req held high.
